// File: rtl/parity_frame_tx.sv
// -----------------------------------------------------------------------------
// parity_frame_tx
//   Serialises a byte and its supplied parity bit as an 11-bit frame:
//   start(0), data[0..7] LSB first, parity, stop(1). Each frame bit is held
//   on tx for CLKS_PER_BIT clocks. The supplied even/odd parity inputs are
//   also cross-checked against the byte at accept time and the result is
//   reported on chk_err. The parity bit is sent exactly as supplied, even
//   when the cross-check fails.
//
// Parameters
//   CLKS_PER_BIT : clocks per frame bit (>= 1)
//   PARITY_ODD   : 0 sends even_parity, 1 sends odd_parity
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   load         in   request a frame (honoured only while idle)
//   data_in[7:0] in   byte to send
//   even_parity  in   even parity bit from the parity stage
//   odd_parity   in   odd parity bit from the parity stage
//   tx           out  serial line, idles high
//   busy         out  frame in progress
//   done         out  one-cycle pulse when the stop bit completes
//   chk_err      out  supplied parity disagreed with data_in at last accept
// -----------------------------------------------------------------------------
module parity_frame_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] data_in,
    input  logic       even_parity,
    input  logic       odd_parity,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic       chk_err
);

    // Clock counter is at least one bit wide so CLKS_PER_BIT=1 still elaborates.
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // True when either supplied parity bit disagrees with the byte.
    function automatic logic parity_mismatch(input logic [7:0] d,
                                             input logic       ev,
                                             input logic       od);
        return (ev != (^d)) || (od != (~^d));
    endfunction

    state_t          r_state;
    logic [CW-1:0]   r_clk_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_data;
    logic            r_par;
    logic            r_tx;
    logic            r_busy;
    logic            r_done;
    logic            r_chk_err;

    logic            w_bit_end;
    logic            w_sel_par;
    logic [2:0]      w_next_idx;

    assign w_bit_end  = (r_clk_cnt == C_LAST);
    assign w_sel_par  = PARITY_ODD ? odd_parity : even_parity;
    assign w_next_idx = r_bit_idx + 3'd1;

    // Frame sequencer: state, counters, latched frame contents and all outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_clk_cnt <= {CW{1'b0}};
            r_bit_idx <= 3'd0;
            r_data    <= 8'd0;
            r_par     <= 1'b0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_chk_err <= 1'b0;
        end else begin
            // done is a single-cycle pulse; only the end of STOP raises it.
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_clk_cnt <= {CW{1'b0}};
                    r_bit_idx <= 3'd0;
                    if (load) begin
                        r_data    <= data_in;
                        r_par     <= w_sel_par;
                        r_chk_err <= parity_mismatch(data_in, even_parity, odd_parity);
                        r_state   <= S_START;
                        r_tx      <= 1'b0;
                        r_busy    <= 1'b1;
                    end else begin
                        r_tx   <= 1'b1;
                        r_busy <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_state   <= S_DATA;
                        r_clk_cnt <= {CW{1'b0}};
                        r_bit_idx <= 3'd0;
                        r_tx      <= r_data[0];
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= {CW{1'b0}};
                        if (r_bit_idx == 3'd7) begin
                            r_state   <= S_PARITY;
                            r_bit_idx <= 3'd0;
                            r_tx      <= r_par;
                        end else begin
                            r_bit_idx <= w_next_idx;
                            r_tx      <= r_data[w_next_idx];
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CW'(1);
                    end
                end
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_state   <= S_STOP;
                        r_clk_cnt <= {CW{1'b0}};
                        r_tx      <= 1'b1;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        r_state   <= S_IDLE;
                        r_clk_cnt <= {CW{1'b0}};
                        r_tx      <= 1'b1;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_clk_cnt <= {CW{1'b0}};
                    r_bit_idx <= 3'd0;
                    r_tx      <= 1'b1;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign tx      = r_tx;
    assign busy    = r_busy;
    assign done    = r_done;
    assign chk_err = r_chk_err;

endmodule
